bridge_reg_responder: RTL and testbench

Leaf-side responder for the Pocket host bridge: it attaches to one `bus_if` leaf port produced by the bridge fan-out and answers its `wr`/`rd` strobes. It holds a bank of 32-bit read/write control registers, a sticky write-1-to-clear event register and a read-only status word. Read data returns through a fixed-latency pipeline with a one-cycle `rd_data_valid` pulse. Cores instantiate it to expose configuration and status to the host without writing bespoke bridge decode.

---
 rtl/bridge_reg_responder.sv | 80 ++++++++
 tb/tb_bridge_reg_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bridge_reg_responder.sv
// bridge_reg_responder: bridge leaf exposing RW control regs, a W1C event reg and a status word with fixed-latency reads
module bridge_reg_responder #(
  parameter logic [31:0]                BASE_ADDR     = 32'h0000_0000,
  parameter int                         NUM_REGS      = 8,
  parameter int                         READ_LATENCY  = 2,
  parameter logic [NUM_REGS-1:0][31:0]  CTRL_RESET    = '0,
  parameter logic [31:0]                UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wr_data,
  input  logic                         wr,
  input  logic                         rd,
  output logic [31:0]                  rd_data,
  output logic                         rd_data_valid,
  output logic [NUM_REGS-1:0][31:0]    ctrl_out,
  output logic [NUM_REGS-1:0]          ctrl_wr_pulse,
  input  logic [31:0]                  event_in,
  input  logic [31:0]                  status_in,
  output logic                         irq
);
  logic [30:0]             word;
  logic [29:0]             idx;
  logic                    mapped, evt_hit, sts_hit;
  logic [NUM_REGS-1:0]     ctrl_hit;
  logic [31:0]             sticky, clr, rd_sel;
  logic [READ_LATENCY-1:0] vld;
  logic [31:0]             dat [READ_LATENCY];

  // word-index decode; the borrow of a 33-bit subtract flags addresses below the base
  always_comb begin
    word = 31'(({1'b0, addr} - {1'b0, BASE_ADDR}) >> 2);
    idx = word[29:0];
    mapped = !word[30];
    evt_hit = mapped && idx == 30'(NUM_REGS);
    sts_hit = mapped && idx == 30'(NUM_REGS + 1);
    clr = wr && evt_hit ? wr_data : '0;
    rd_sel = evt_hit ? sticky : sts_hit ? status_in : UNMAPPED_DATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      ctrl_hit[i] = mapped && idx == 30'(i);
      if (ctrl_hit[i]) rd_sel = ctrl_out[i];
    end
  end

  // control registers and their one-cycle write strobes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl_out <= CTRL_RESET;
      ctrl_wr_pulse <= '0;
    end else begin
      ctrl_wr_pulse <= wr ? ctrl_hit : '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr && ctrl_hit[i]) ctrl_out[i] <= wr_data;
    end

  // sticky events; a set on the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset)
    if (reset) sticky <= '0;
    else sticky <= (sticky & ~clr) | event_in;

  assign irq = |sticky;

  // read pipeline; data only advances with its valid so rd_data holds between pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) dat[k] <= '0;
    end else begin
      vld[0] <= rd;
      if (rd) dat[0] <= rd_sel;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end

  assign rd_data = dat[READ_LATENCY-1];
  assign rd_data_valid = vld[READ_LATENCY-1];
endmodule

// File: tb/tb_bridge_reg_responder.sv
// tb_bridge_reg_responder: scoreboard bench driving three latency variants from one reference model
module tb_bridge_reg_responder;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [7:0][31:0] CR = 256'h5A << 96;
  typedef struct { logic [31:0] data; int cyc; } exp_t;

  logic clk = 0, reset = 0, wr = 0, rd = 0, started = 0;
  logic [31:0] addr = 0, wr_data = 0, event_in = 0, status_in = 0;
  logic [7:0][31:0] co [3];
  logic [7:0] cp [3];
  logic iq [3], rv [3];
  logic [31:0] rdd [3];
  int lat [3] = '{2, 1, 4};
  exp_t q [3][$];
  logic [31:0] last [3];
  logic [31:0] m_ctrl [8];
  logic [31:0] m_sticky = 0;
  logic [7:0] m_pulse = 0;
  int cyc = 0, compared = 0, mismatched = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bridge_reg_responder #(
      .BASE_ADDR(BASE), .NUM_REGS(8), .READ_LATENCY(g == 0 ? 2 : g == 1 ? 1 : 4),
      .CTRL_RESET(CR), .UNMAPPED_DATA(32'hDEAD_BEEF)
    ) u_dut (
      .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data), .wr(wr), .rd(rd),
      .rd_data(rdd[g]), .rd_data_valid(rv[g]), .ctrl_out(co[g]), .ctrl_wr_pulse(cp[g]),
      .event_in(event_in), .status_in(status_in), .irq(iq[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a < BASE) return -1;
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] st);
    int i;
    i = decode(a);
    if (i >= 0 && i < 8) return m_ctrl[i];
    if (i == 8) return m_sticky;
    if (i == 9) return st;
    return 32'hDEAD_BEEF;
  endfunction

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ev, input logic [31:0] st);
    int i;
    logic [31:0] clr;
    i = decode(a);
    clr = 0;
    wr = w; rd = r; addr = a; wr_data = d; event_in = ev; status_in = st;
    if (r) for (int j = 0; j < 3; j++) q[j].push_back('{data: model_read(a, st), cyc: cyc + lat[j]});
    @(posedge clk);
    m_pulse = 0;
    if (w && i >= 0 && i < 8) begin
      m_ctrl[i] = d;
      m_pulse[i] = 1;
    end
    if (w && i == 8) clr = d;
    m_sticky = (m_sticky & ~clr) | ev;
    #1;
    wr = 0; rd = 0; event_in = 0;
  endtask

  always @(negedge clk) if (started) begin
    exp_t e;
    for (int i = 0; i < 8; i++) check($sformatf("ctrl_out[%0d]", i), co[0][i], m_ctrl[i]);
    check("ctrl_wr_pulse", {24'h0, cp[0]}, {24'h0, m_pulse});
    check("irq", {31'h0, iq[0]}, {31'h0, |m_sticky});
    for (int j = 0; j < 3; j++) begin
      while (q[j].size() > 0 && q[j][0].cyc < cyc) begin
        e = q[j].pop_front();
        check($sformatf("missing_valid_L%0d", lat[j]), cyc, e.cyc);
      end
      if (reset) last[j] = 0;
      else if (rv[j]) begin
        if (q[j].size() == 0) check($sformatf("unexpected_valid_L%0d", lat[j]), {31'h0, rv[j]}, 0);
        else begin
          e = q[j].pop_front();
          check($sformatf("rd_data_L%0d", lat[j]), rdd[j], e.data);
          check($sformatf("valid_cycle_L%0d", lat[j]), cyc, e.cyc);
        end
        last[j] = rdd[j];
      end else check($sformatf("rd_data_hold_L%0d", lat[j]), rdd[j], last[j]);
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 8; i++) m_ctrl[i] = CR[i];
    #1 reset = 1;
    started = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    step(0, 1, 32'h10C, 0, 0, 0);
    step(0, 1, 32'h124, 0, 0, 32'h1234);
    step(1, 0, 32'h104, 32'hCAFE_F00D, 0, 0);
    step(0, 1, 32'h104, 0, 0, 0);
    step(0, 0, 0, 0, 32'h11, 0);
    step(0, 1, 32'h120, 0, 0, 0);
    step(1, 0, 32'h120, 32'h1, 0, 0);
    step(0, 1, 32'h120, 0, 0, 0);
    step(1, 0, 32'h120, 32'h10, 32'h10, 0);
    step(0, 1, 32'h120, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 0, BASE + 4 * k, 32'hA0 + k, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, BASE + 4 * k, 0, 0, 0);
    step(0, 1, 32'h0FC, 0, 0, 0);
    step(0, 1, 32'h200, 0, 0, 0);
    step(1, 0, 32'h200, 32'hFFFF_FFFF, 0, 0);
    step(1, 1, 32'h108, 32'h77, 0, 0);
    step(0, 1, 32'h108, 0, 0, 0);
    repeat (400) begin
      a = BASE - 8 + 4 * $urandom_range(0, 13) + $urandom_range(0, 3);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, $urandom,
           $urandom & $urandom & $urandom, $urandom);
    end
    step(1, 0, 32'h10C, 32'h1234_5678, 0, 0);
    step(0, 1, 32'h10C, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10C, 0, 0, 0);
    reset = 1;
    for (int j = 0; j < 3; j++) q[j].delete();
    for (int i = 0; i < 8; i++) m_ctrl[i] = CR[i];
    m_sticky = 0;
    m_pulse = 0;
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset_rd_data_L%0d", lat[j]), rdd[j], 0);
      check($sformatf("reset_rd_valid_L%0d", lat[j]), {31'h0, rv[j]}, 0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (8) step(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) check($sformatf("pending_L%0d", lat[j]), q[j].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
